// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: zero-fills the register file after reset, then arbitrates
// ALU and load writebacks onto one registered write port and tracks in-flight destinations.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter bit INIT_ZERO    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    input  logic        pend_set_valid,
    input  logic [4:0]  pend_set_addr,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic [4:0]  addr_D,
    output logic [31:0] data_D,
    output logic        reg_write_en,
    output logic        init_done
);

    localparam int SW = ($clog2(STARVE_LIMIT + 1) > 2) ? $clog2(STARVE_LIMIT + 1) : 2;

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    localparam state_t RESET_STATE = (INIT_ZERO != 1'b0) ? ST_INIT : ST_RUN;

    state_t         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic           wr_en_q, wr_en_d;
    logic [4:0]     addr_q, addr_d;
    logic [31:0]    data_q, data_d;
    logic [31:0]    pending_q, pending_d;
    logic           starve_full;
    logic           set_en;

    assign starve_full = (starve_q == SW'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && cnt_q == 5'd31) begin
            state_d = ST_RUN;
        end
    end

    // Reset gates the write port so a granted-but-uncommitted write never reaches the file.
    always_comb begin
        alu_ready    = 1'b0;
        ld_ready     = 1'b0;
        init_done    = 1'b0;
        reg_write_en = 1'b0;
        addr_D       = addr_q;
        data_D       = data_q;
        if (!reset) begin
            if (state_q == ST_INIT) begin
                reg_write_en = 1'b1;
                addr_D       = cnt_q;
                data_D       = '0;
            end else begin
                init_done    = 1'b1;
                reg_write_en = wr_en_q;
                alu_ready    = alu_valid && !(ld_valid && starve_full);
                ld_ready     = ld_valid && (!alu_valid || starve_full);
            end
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        starve_d = '0;
        wr_en_d  = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        if (state_q == ST_INIT) begin
            cnt_d  = cnt_q + 5'd1;
            addr_d = cnt_q;
            data_d = '0;
        end else begin
            if (ld_ready || !ld_valid) begin
                starve_d = '0;
            end else if (alu_ready && !starve_full) begin
                starve_d = starve_q + SW'(1);
            end else begin
                starve_d = starve_q;
            end
            // Writes to x0 are accepted but dropped; the port keeps its previous contents.
            if (alu_ready && alu_addr != 5'd0) begin
                wr_en_d = 1'b1;
                addr_d  = alu_addr;
                data_d  = alu_data;
            end else if (ld_ready && ld_addr != 5'd0) begin
                wr_en_d = 1'b1;
                addr_d  = ld_addr;
                data_d  = ld_data;
            end
        end
    end

    assign set_en       = pend_set_valid && (state_q == ST_RUN);
    assign pending_d[0] = 1'b0;

    // Set beats clear so an immediate re-issue to the same rd stays busy.
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_pend
            assign pending_d[gi] = (set_en && pend_set_addr == 5'(gi)) ||
                                   (pending_q[gi] && !(reg_write_en && addr_D == 5'(gi)));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            starve_q  <= '0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            pending_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            pending_q <= pending_d;
        end
    end

    assign rs1_busy = pending_q[rs1_addr];
    assign rs2_busy = pending_q[rs2_addr];

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: max consecutive ALU grants while a load request waits.
REQ-002 SHALL have parameter INIT_ZERO, default 1: 1 = zero-fill all 32 registers after reset; 0 = skip directly to RUN.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock) and reset (input, 1, synchronous active-high reset).
REQ-004 SHALL have alu_valid, alu_ready (in, out, 1 each): ALU writeback handshake.
REQ-005 SHALL have alu_addr (in, 5) and alu_data (in, 32): ALU destination register and result.
REQ-006 SHALL have ld_valid, ld_ready (in, out, 1 each): load-unit writeback handshake.
REQ-007 SHALL have ld_addr (in, 5) and ld_data (in, 32): load destination register and data.
REQ-008 SHALL have pend_set_valid (in, 1) and pend_set_addr (in, 5): issue stage marks rd as in-flight.
REQ-009 SHALL have rs1_addr, rs2_addr (in, 5 each) and rs1_busy, rs2_busy (out, 1 each): scoreboard lookup.
REQ-010 SHALL have addr_D (out, 5), data_D (out, 32) and reg_write_en (out, 1): registered register-file write port.
REQ-011 SHALL have init_done (out, 1): high once INIT completes.

Function
REQ-012 SHALL implement two states, INIT and RUN; reset enters INIT (or RUN when INIT_ZERO=0).
REQ-013 In INIT, a 5-bit counter SHALL drive addr_D=count, data_D=0, reg_write_en=1 each cycle, from 0 through 31 (32 cycles); after the count-31 write it SHALL enter RUN.
REQ-014 In INIT, alu_ready, ld_ready and init_done SHALL be 0; pend_set_valid SHALL be ignored.
REQ-015 In RUN, init_done=1; a transfer occurs when valid && ready on the same rising edge.
REQ-016 At most one requester SHALL be granted per cycle; ready SHALL be driven combinationally from valid inputs and the starvation counter, never from data.
REQ-017 Default priority: ALU wins when both valid; ld_ready=1 when ld_valid and (!alu_valid or starve count == STARVE_LIMIT).
REQ-018 Starve counter (2+ bits) SHALL increment on each ALU grant while ld_valid=1, clear on any load grant or when ld_valid=0, and saturate at STARVE_LIMIT.
REQ-019 A granted transfer at edge N SHALL appear on addr_D/data_D with reg_write_en=1 during cycle N..N+1 (1-cycle latency); the register file captures it at edge N+1.
REQ-020 Idle cycles SHALL drive reg_write_en=0; addr_D/data_D hold their last value.
REQ-021 Transfers addressed to x0 SHALL be accepted (ready asserted normally) but SHALL produce reg_write_en=0.
REQ-022 The scoreboard SHALL be a 32-bit pending vector; bit 0 is constant 0.
REQ-023 pend_set_valid with nonzero pend_set_addr SHALL set that pending bit at the next edge.
REQ-024 A pending bit SHALL clear on the edge where reg_write_en=1 with addr_D equal to that bit's index, i.e. the same edge the register file captures the data.
REQ-025 Simultaneous set and clear of the same bit SHALL leave the bit set.
REQ-026 rsN_busy SHALL equal pending[rsN_addr], combinationally; address 0 always reads not-busy.

Reset
REQ-027 When reset=1 at a rising edge: state <= INIT (or RUN if INIT_ZERO=0), init counter <= 0, starve counter <= 0, pending <= 0, reg_write_en <= 0, addr_D <= 0, data_D <= 0.
REQ-028 Reset asserted in RUN or INIT SHALL discard any granted-but-uncommitted write and restart the INIT sequence.
REQ-029 While reset=1, alu_ready=ld_ready=init_done=0.

Verification
REQ-030 Reset then idle: reg_write_en=1 for exactly 32 cycles with addr_D 0..31 and data_D=0; init_done rises the following cycle; no ready is asserted before that.
REQ-031 ALU-only write (alu_addr=5, alu_data=0x1234_5678) -> next cycle addr_D=5, data_D=0x12345678, reg_write_en=1; only alu_ready was asserted.
REQ-032 Both valid continuously, STARVE_LIMIT=3 -> grant order ALU, ALU, ALU, LD, repeating; the load is never delayed by more than 3 cycles.
REQ-033 Pending x7 set, then load to x7 granted at edge N -> rs1_busy (rs1_addr=7) stays 1 through cycle N and drops after edge N+1.
REQ-034 ALU write to x0 with data 0xFFFF_FFFF -> alu_ready=1, reg_write_en stays 0; pend_set to x0 leaves rs busy=0.
REQ-035 Reset pulsed mid-RUN with a write granted the prior cycle -> no write commits, pending vector clears, INIT restarts at addr_D=0.
